// File: rtl/fxu_rs_if.sv
// Dispatch, result-bus and issue signals shared by the FXU reservation station
// and its neighbours (instruction buffer, CDB, fixed-point unit).
interface fxu_rs_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic [TAG_W-1:0]  in_rob_idx;
  logic [3:0]        in_opcode;
  logic [7:0]        in_i;
  logic              in_a_valid;
  logic [DATA_W-1:0] in_a_value;
  logic [TAG_W-1:0]  in_a_owner;
  logic              in_b_valid;
  logic [DATA_W-1:0] in_b_value;
  logic [TAG_W-1:0]  in_b_owner;
  logic              full;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_rob_idx;
  logic [DATA_W-1:0] cdb_value;

  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_rob_idx;
  logic [3:0]        out_opcode;
  logic [7:0]        out_i;
  logic [DATA_W-1:0] out_a_value;
  logic [DATA_W-1:0] out_b_value;

  modport master (
    output in_valid, in_rob_idx, in_opcode, in_i,
    output in_a_valid, in_a_value, in_a_owner,
    output in_b_valid, in_b_value, in_b_owner,
    output cdb_valid, cdb_rob_idx, cdb_value, out_ready,
    input  full, out_valid, out_rob_idx, out_opcode, out_i, out_a_value, out_b_value
  );

  modport slave (
    input  in_valid, in_rob_idx, in_opcode, in_i,
    input  in_a_valid, in_a_value, in_a_owner,
    input  in_b_valid, in_b_value, in_b_owner,
    input  cdb_valid, cdb_rob_idx, cdb_value, out_ready,
    output full, out_valid, out_rob_idx, out_opcode, out_i, out_a_value, out_b_value
  );
endinterface

// File: rtl/fxu_reservation_station.sv
// Compacting age-ordered issue queue for one FXU: entry 0 is the oldest, the
// oldest ready entry issues, and operands are woken by snooping the result bus.
module fxu_reservation_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input logic    clk,
  input logic    rst,
  input logic    flush,
  fxu_rs_if.slave bus
);
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  rob_idx;
    logic [3:0]        opcode;
    logic [7:0]        i;
    logic              a_rdy;
    logic [DATA_W-1:0] a_val;
    logic [TAG_W-1:0]  a_tag;
    logic              b_rdy;
    logic [DATA_W-1:0] b_val;
    logic [TAG_W-1:0]  b_tag;
  } entry_t;

  entry_t           q_reg  [DEPTH];
  entry_t           q_next [DEPTH];
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg;

  logic [DEPTH-1:0] ready;
  logic [SEL_W-1:0] sel;
  logic             any_ready;
  logic             issue;
  logic             dispatch;
  logic [CNT_W-1:0] wr_pos;
  entry_t           new_entry;
  entry_t           sel_entry;

  // Downward scan leaves the lowest-index (oldest) ready entry selected.
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel       = SEL_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign issue    = any_ready & bus.out_ready;
  assign dispatch = bus.in_valid & ~full_reg;
  assign wr_pos   = count_reg - CNT_W'(issue);

  always_comb begin
    new_entry         = '0;
    new_entry.busy    = 1'b1;
    new_entry.rob_idx = bus.in_rob_idx;
    new_entry.opcode  = bus.in_opcode;
    new_entry.i       = bus.in_i;
    new_entry.a_tag   = bus.in_a_owner;
    new_entry.b_tag   = bus.in_b_owner;
    if (bus.in_a_valid) begin
      new_entry.a_rdy = 1'b1;
      new_entry.a_val = bus.in_a_value;
    end else if (bus.cdb_valid && bus.in_a_owner == bus.cdb_rob_idx) begin
      new_entry.a_rdy = 1'b1;
      new_entry.a_val = bus.cdb_value;
    end
    if (bus.in_b_valid) begin
      new_entry.b_rdy = 1'b1;
      new_entry.b_val = bus.in_b_value;
    end else if (bus.cdb_valid && bus.in_b_owner == bus.cdb_rob_idx) begin
      new_entry.b_rdy = 1'b1;
      new_entry.b_val = bus.cdb_value;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    entry_t shifted;
    entry_t nxt;

    assign ready[gi] = q_reg[gi].busy & q_reg[gi].a_rdy & q_reg[gi].b_rdy;

    // Entries at and above the issuing slot move down one to close the gap.
    if (gi < DEPTH - 1) begin : g_shift
      assign shifted = (issue && SEL_W'(gi) >= sel) ? q_reg[gi+1] : q_reg[gi];
    end else begin : g_last
      assign shifted = (issue && SEL_W'(gi) >= sel) ? '0 : q_reg[gi];
    end

    always_comb begin
      nxt = shifted;
      if (bus.cdb_valid && shifted.busy && !shifted.a_rdy && shifted.a_tag == bus.cdb_rob_idx) begin
        nxt.a_rdy = 1'b1;
        nxt.a_val = bus.cdb_value;
      end
      if (bus.cdb_valid && shifted.busy && !shifted.b_rdy && shifted.b_tag == bus.cdb_rob_idx) begin
        nxt.b_rdy = 1'b1;
        nxt.b_val = bus.cdb_value;
      end
      if (dispatch && wr_pos == CNT_W'(gi)) begin
        nxt = new_entry;
      end
    end

    assign q_next[gi] = nxt;
  end

  assign count_next = count_reg + CNT_W'(dispatch) - CNT_W'(issue);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i] <= '0;
      end
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i] <= q_next[i];
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
    end
  end

  assign sel_entry       = q_reg[sel];
  assign bus.full        = full_reg;
  assign bus.out_valid   = any_ready;
  assign bus.out_rob_idx = any_ready ? sel_entry.rob_idx : '0;
  assign bus.out_opcode  = any_ready ? sel_entry.opcode  : '0;
  assign bus.out_i       = any_ready ? sel_entry.i       : '0;
  assign bus.out_a_value = any_ready ? sel_entry.a_val   : '0;
  assign bus.out_b_value = any_ready ? sel_entry.b_val   : '0;
endmodule

// File: doc/fxu_reservation_station.md
Name: fxu_reservation_station

Overview:
- Per-FXU issue queue between the instruction buffer and one fixed-point unit.
- Accepts one dispatched instruction per cycle, with operands either captured as values or tagged by ROB owner.
- Snoops the result bus to wake waiting operands.
- Issues the oldest fully-ready entry to the FXU over a valid/ready handshake; drives `full` back to the instruction buffer's FXU slot-assignment logic.

Parameters:
- DEPTH, 4, number of entries (2..8).
- DATA_W, 16, operand/result width.
- TAG_W, 4, ROB index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of all entries (mispredict); same effect as rst.
- in_valid  in  1  dispatch request.
- in_rob_idx  in  TAG_W  destination ROB index.
- in_opcode  in  4  FXU opcode.
- in_i  in  8  immediate.
- in_a_valid  in  1  operand A value present.
- in_a_value  in  DATA_W  operand A value.
- in_a_owner  in  TAG_W  ROB tag A waits on.
- in_b_valid, in_b_value, in_b_owner  in  1/DATA_W/TAG_W  same for operand B.
- full  out  1  no free entry; registered.
- cdb_valid  in  1  result broadcast valid.
- cdb_rob_idx  in  TAG_W  producing ROB index.
- cdb_value  in  DATA_W  result value.
- out_valid  out  1  an issuable entry exists.
- out_ready  in  1  FXU accepts this cycle.
- out_rob_idx  out  TAG_W  issued instruction's ROB index.
- out_opcode  out  4  issued opcode.
- out_i  out  8  issued immediate.
- out_a_value  out  DATA_W  issued operand A.
- out_b_value  out  DATA_W  issued operand B.

Behaviour:
- **Storage:** compacting age queue. Entry 0 is the oldest. Per entry: busy, rob_idx, opcode, i, a_rdy, a_val, a_tag, b_rdy, b_val, b_tag. Occupancy count 0..DEPTH.
- **Reset / flush:** on rst or flush, all busy=0 and count=0 at the next edge.
  - Outputs after reset: full=0, out_valid=0, all out_* data fields=0.
  - rst/flush override any same-cycle dispatch, issue or wakeup.
- **Ready:** entry is ready when busy & a_rdy & b_rdy.
- **Select and issue:**
  - out_valid = OR over entries of ready.
  - Selected entry = lowest-index ready entry, which is the oldest.
  - out_* are combinational from the selected entry and are 0 when out_valid=0.
  - An issue fires when out_valid & out_ready. Latency from last operand ready to out_valid is 0 cycles, since it is taken from the registered state.
  - While out_valid & ~out_ready, out_* stay stable unless an older entry becomes ready, which then takes priority.
- **Removal:** at the edge of an issue, the selected entry k is removed. Entries k+1..count-1 shift down by one. count decrements.
- **Dispatch:**
  - When in_valid & ~full, the new entry is written at position count − (issue ? 1 : 0), i.e. after compaction. count increments.
  - Issue and dispatch in the same cycle leave count unchanged.
  - in_valid while full is ignored, and the bench flags it as a protocol error.
  - full is registered: full = (count_next == DEPTH). No same-cycle full release: a slot freed by an issue is usable from the next cycle.
- **Wakeup:**
  - On cdb_valid, every busy entry with ~a_rdy & a_tag==cdb_rob_idx sets a_rdy=1 and a_val=cdb_value; the same applies to B.
  - Wakeup applies to shifting entries at their new position.
  - Dispatch bypass: if the incoming operand is not valid and cdb_valid & in_x_owner==cdb_rob_idx in the dispatch cycle, it is stored as ready with cdb_value.
  - An entry woken at edge N may issue in cycle N+1, not earlier.
- **Ordering:** no wrap-around arithmetic on tags. Age comes purely from queue position; tags are compared for equality only.
- **Invariants:**
  - busy entries are contiguous from 0.
  - count equals the number of busy entries.
  - An entry never issues twice.

Test Plan:
1. After rst, dispatch rob 3, opcode 0, A=5 ready, B=7 ready, out_ready=1 → out_valid=1 the next cycle with out_rob_idx=3, out_a_value=5, out_b_value=7; queue empty after that edge.
2. Dispatch rob 1 with A waiting on tag 9, then rob 2 fully ready, out_ready=1 → rob 2 issues first. Then cdb_valid, idx 9, value 0x00AA → rob 1 issues the following cycle with out_a_value=0x00AA.
3. Four ready dispatches with out_ready=0 → full=1 after the 4th edge and a 5th in_valid is ignored. Raise out_ready → issue order is rob_idx in dispatch order; full drops one cycle after the first issue.
4. Dispatch whose A owner is 6 while cdb_valid idx 6 value 0x1234 in the same cycle → entry is ready and issues the next cycle with A=0x1234.
5. Three entries present and issuing entry 1 while dispatching → new entry lands at position 2, and the former entry 2 shifts to position 1; check order.
6. Assert flush, or rst, with 3 busy entries and a simultaneous dispatch → count=0, full=0, out_valid=0 next cycle; the dispatched instruction is dropped.
